// File: rtl/fft_ctrl_fsm.sv
// Sequencing FSM for the 4-point FFT engine: a debounced push-button walks LOAD/COMPUTE/OUT.
// Define FSM_WATCHDOG_EN to enable the compute watchdog and the sticky err_flag.
module fft_ctrl_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       fft_done,
  output logic [3:0] fsm_state_out,
  output logic       load_en,
  output logic [1:0] load_idx,
  output logic       fft_start,
  output logic       out_en,
  output logic [1:0] out_idx,
  output logic       err_flag
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StLoad1   = 4'd1,
    StLoad2   = 4'd2,
    StLoad3   = 4'd3,
    StLoad4   = 4'd4,
    StCompute = 4'd5,
    StOut1    = 4'd6,
    StOut2    = 4'd7,
    StOut3    = 4'd8,
    StOut4    = 4'd9
  } state_e;

  logic           btn_meta_q, btn_sync_q;
  logic           db_level_q, db_level_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           press_q, press_d;

  state_e     state_q, state_d;
  logic       load_en_q, load_en_d;
  logic [1:0] load_idx_q, load_idx_d;
  logic       fft_start_q, fft_start_d;
  logic       out_en_q, out_en_d;
  logic [1:0] out_idx_q, out_idx_d;
  logic       wd_expired;

  // Counter only runs while the synced button disagrees with the accepted level.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press_d    = 1'b0;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = btn_sync_q;
        press_d    = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn_in;
      btn_sync_q <= btn_meta_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_en_d   = 1'b0;
    load_idx_d  = load_idx_q;
    fft_start_d = 1'b0;
    unique case (state_q)
      StIdle:  if (press_q) state_d = StLoad1;
      StLoad1: if (press_q) begin
        state_d    = StLoad2;
        load_en_d  = 1'b1;
        load_idx_d = 2'd0;
      end
      StLoad2: if (press_q) begin
        state_d    = StLoad3;
        load_en_d  = 1'b1;
        load_idx_d = 2'd1;
      end
      StLoad3: if (press_q) begin
        state_d    = StLoad4;
        load_en_d  = 1'b1;
        load_idx_d = 2'd2;
      end
      StLoad4: if (press_q) begin
        state_d     = StCompute;
        load_en_d   = 1'b1;
        load_idx_d  = 2'd3;
        fft_start_d = 1'b1;
      end
      // fft_done has priority over both a press and the watchdog.
      StCompute: begin
        if (fft_done) state_d = StOut1;
        else if (wd_expired) state_d = StIdle;
      end
      StOut1:  if (press_q) state_d = StOut2;
      StOut2:  if (press_q) state_d = StOut3;
      StOut3:  if (press_q) state_d = StOut4;
      StOut4:  if (press_q) state_d = StLoad1;
      default: state_d = StIdle;
    endcase

    out_en_d  = 1'b0;
    out_idx_d = 2'd0;
    case (state_d)
      StOut1:  begin out_en_d = 1'b1; out_idx_d = 2'd0; end
      StOut2:  begin out_en_d = 1'b1; out_idx_d = 2'd1; end
      StOut3:  begin out_en_d = 1'b1; out_idx_d = 2'd2; end
      StOut4:  begin out_en_d = 1'b1; out_idx_d = 2'd3; end
      default: begin out_en_d = 1'b0; out_idx_d = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      load_en_q   <= 1'b0;
      load_idx_q  <= 2'd0;
      fft_start_q <= 1'b0;
      out_en_q    <= 1'b0;
      out_idx_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      load_en_q   <= load_en_d;
      load_idx_q  <= load_idx_d;
      fft_start_q <= fft_start_d;
      out_en_q    <= out_en_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef FSM_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           err_q;

  // Counter is zero on the first COMPUTE cycle; expiry on the last allowed one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == StCompute) ? wd_cnt_q + 1'b1 : '0;
      if ((state_q == StCompute) && !fft_done && wd_expired) begin
        err_q <= 1'b1;
      end else if ((state_q == StIdle) && press_q) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wd_expired = (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
  assign err_flag   = err_q;
`else
  assign wd_expired = 1'b0;
  assign err_flag   = 1'b0;
`endif

  assign fsm_state_out = state_q;
  assign load_en       = load_en_q;
  assign load_idx      = load_idx_q;
  assign fft_start     = fft_start_q;
  assign out_en        = out_en_q;
  assign out_idx       = out_idx_q;

endmodule

// File: tb/tb_fft_ctrl_fsm.sv
// Directed, table-driven bench for fft_ctrl_fsm (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_fft_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       fft_done;
  logic [3:0] fsm_state_out;
  logic       load_en;
  logic [1:0] load_idx;
  logic       fft_start;
  logic       out_en;
  logic [1:0] out_idx;
  logic       err_flag;

  fft_ctrl_fsm #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .fft_done     (fft_done),
    .fsm_state_out(fsm_state_out),
    .load_en      (load_en),
    .load_idx     (load_idx),
    .fft_start    (fft_start),
    .out_en       (out_en),
    .out_idx      (out_idx),
    .err_flag     (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         is_done;
    logic [3:0] code;
    bit         le;
    logic [1:0] li;
    bit         fs;
    bit         oe;
    logic [1:0] oi;
  } vec_t;

  vec_t vecs[10];

  int n_cmp;
  int n_err;

  logic [3:0] cap_code;
  logic       cap_le;
  logic [1:0] cap_li;
  logic       cap_fs;
  logic       cap_oe;
  logic [1:0] cap_oi;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    cap_code = fsm_state_out;
    cap_le   = load_en;
    cap_li   = load_idx;
    cap_fs   = fft_start;
    cap_oe   = out_en;
    cap_oi   = out_idx;
  endtask

  // Bounded wait for the state code to move; the sample that shows the move is captured.
  task automatic wait_change();
    logic [3:0] prev;
    bit         seen;
    prev = fsm_state_out;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (fsm_state_out != prev) seen = 1'b1;
    end
    capture();
    check("advance_seen", int'(seen), 1);
  endtask

  task automatic press_step();
    btn_in = 1'b1;
    wait_change();
    tick();
    check("load_en_one_cycle", int'(load_en), 0);
    check("fft_start_one_cycle", int'(fft_start), 0);
    repeat (5) tick();
    check("held_no_replay", int'(fsm_state_out), int'(cap_code));
    btn_in = 1'b0;
    repeat (10) tick();
    check("release_quiet", int'(fsm_state_out), int'(cap_code));
  endtask

  task automatic compute_hold();
    btn_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("compute_ignores_press", int'(fsm_state_out), 5);
    end
    btn_in = 1'b0;
    repeat (10) tick();
    check("compute_after_release", int'(fsm_state_out), 5);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(fsm_state_out), 0);
    check({tag, "_load_en"}, int'(load_en), 0);
    check({tag, "_load_idx"}, int'(load_idx), 0);
    check({tag, "_fft_start"}, int'(fft_start), 0);
    check({tag, "_out_en"}, int'(out_en), 0);
    check({tag, "_out_idx"}, int'(out_idx), 0);
    check({tag, "_err_flag"}, int'(err_flag), 0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    btn_in   = 1'b0;
    fft_done = 1'b0;

    vecs[0] = '{1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 4'd2, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 4'd3, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{1'b0, 4'd4, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{1'b0, 4'd5, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{1'b1, 4'd6, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[6] = '{1'b0, 4'd7, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1};
    vecs[7] = '{1'b0, 4'd8, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2};
    vecs[8] = '{1'b0, 4'd9, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3};
    vecs[9] = '{1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("idle");

    // fft_done outside COMPUTE must not move the FSM.
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    repeat (3) tick();
    check("done_in_idle", int'(fsm_state_out), 0);

    // Glitches shorter than the debounce window.
    btn_in = 1'b1;
    tick();
    btn_in = 1'b0;
    repeat (12) tick();
    check("glitch1_state", int'(fsm_state_out), 0);
    btn_in = 1'b1;
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (12) tick();
    check("glitch3_state", int'(fsm_state_out), 0);
    check("glitch3_load_en", int'(load_en), 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) compute_hold();
      if (vecs[i].is_done) begin
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        capture();
      end else begin
        press_step();
      end
      check($sformatf("vec%0d_code", i), int'(cap_code), int'(vecs[i].code));
      check($sformatf("vec%0d_load_en", i), int'(cap_le), int'(vecs[i].le));
      if (vecs[i].le) check($sformatf("vec%0d_load_idx", i), int'(cap_li), int'(vecs[i].li));
      check($sformatf("vec%0d_fft_start", i), int'(cap_fs), int'(vecs[i].fs));
      check($sformatf("vec%0d_out_en", i), int'(cap_oe), int'(vecs[i].oe));
      check($sformatf("vec%0d_out_idx", i), int'(cap_oi), int'(vecs[i].oi));
      check($sformatf("vec%0d_err_flag", i), int'(err_flag), 0);
    end

    // fft_done in the same cycle as fft_start.
    for (int k = 2; k <= 4; k++) begin
      press_step();
      check("frame2_load_code", int'(cap_code), k);
    end
    btn_in = 1'b1;
    wait_change();
    check("same_cycle_code5", int'(cap_code), 5);
    check("same_cycle_start", int'(cap_fs), 1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("same_cycle_out1", int'(fsm_state_out), 6);
    check("same_cycle_out_en", int'(out_en), 1);
    check("same_cycle_out_idx", int'(out_idx), 0);
    btn_in = 1'b0;
    repeat (10) tick();
    check("out1_hold_no_replay", int'(fsm_state_out), 6);
    for (int k = 7; k <= 10; k++) begin
      press_step();
      check("frame2_out_code", int'(cap_code), (k == 10) ? 1 : k);
    end

    // Async reset while load_en is high at code 3.
    press_step();
    check("pre_reset_code2", int'(cap_code), 2);
    btn_in = 1'b1;
    wait_change();
    check("pre_reset_code3", int'(cap_code), 3);
    check("pre_reset_load_en", int'(cap_le), 1);
    rst_n  = 1'b0;
    btn_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    #20;
    rst_n = 1'b1;
    repeat (12) tick();
    check("post_reset_idle", int'(fsm_state_out), 0);
    press_step();
    check("post_reset_press", int'(cap_code), 1);

`ifdef FSM_WATCHDOG_EN
    for (int k = 2; k <= 4; k++) press_step();
    btn_in = 1'b1;
    wait_change();
    check("wd_enter_compute", int'(cap_code), 5);
    begin
      int n;
      n = 1;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (fsm_state_out != 4'd5) break;
        n++;
      end
      check("wd_compute_cycles", n, 64);
    end
    check("wd_timeout_idle", int'(fsm_state_out), 0);
    check("wd_err_set", int'(err_flag), 1);
    btn_in = 1'b0;
    repeat (10) tick();
    press_step();
    check("wd_press_code1", int'(cap_code), 1);
    check("wd_err_cleared", int'(err_flag), 0);

    for (int k = 2; k <= 4; k++) press_step();
    btn_in = 1'b1;
    wait_change();
    check("wd2_enter_compute", int'(cap_code), 5);
    repeat (63) tick();
    check("wd2_cycle64_compute", int'(fsm_state_out), 5);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("wd2_done_wins_code", int'(fsm_state_out), 6);
    check("wd2_done_wins_err", int'(err_flag), 0);
    btn_in = 1'b0;
    repeat (10) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_ctrl_fsm.md
Name: fft_ctrl_fsm

Overview:
Top-level sequencing FSM for the 4-point FFT engine, driven by a single user push-button.
- Debounces the button.
- Walks the user through loading 4 samples, launching the compute, and stepping through 4 results.
- Emits the 4-bit state code consumed by the 7-segment display stage, plus load/start/output-select strobes to the datapath.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized-button cycles required to accept a level change (>=1)
TIMEOUT_CYCLES, 64, compute watchdog limit in cycles (used only with FSM_WATCHDOG_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, reset is asynchronous and active-low
btn_in  input  1  raw asynchronous push-button, active-high
fft_done  input  1  datapath compute-complete, sampled only in COMPUTE
fsm_state_out  output  4  state code to display stage (0..9)
load_en  output  1  one-cycle strobe: latch current input sample
load_idx  output  2  sample slot for load_en (0..3)
fft_start  output  1  one-cycle compute launch strobe
out_en  output  1  high while in any OUT state
out_idx  output  2  result index selected for output (0..3)
err_flag  output  1  sticky compute-timeout indicator

Behaviour:
- All outputs registered. Reset values: fsm_state_out=0, load_en=0, load_idx=0, fft_start=0, out_en=0, out_idx=0, err_flag=0. Debounced level=0, counters=0.
- Button path:
  - 2-flop synchronizer feeds the debouncer.
  - Debounced level flips only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - press = one-cycle pulse on the debounced 0->1 edge. Release generates nothing.
- States and codes:
  - IDLE=0
  - LOAD1..LOAD4 = 1..4
  - COMPUTE = 5
  - OUT1..OUT4 = 6..9
  - Codes 10..15 are never produced.
- Transitions (all taken on the press cycle edge unless noted):
  - IDLE: press -> LOAD1. No load strobe.
  - LOADk: press -> load_en=1 for exactly one cycle with load_idx=k-1, coincident with the new state. LOADk -> LOADk+1; LOAD4 -> COMPUTE.
  - LOAD4 -> COMPUTE: fft_start=1 for exactly one cycle, coincident with entry to COMPUTE.
  - COMPUTE: fft_done=1 -> OUT1 on the next edge, including when done arrives in the same cycle fft_start is high. press is ignored.
  - OUTk: out_en=1 and out_idx=k-1 throughout. press -> OUTk+1; OUT4 press -> LOAD1 (new frame, no IDLE visit).
- fft_done outside COMPUTE is ignored.
- A press already counted is never replayed: a held button gives exactly one advance.
- Async reset mid-operation returns immediately to IDLE with all outputs at their reset values, including pending strobes and err_flag.
- Simultaneous press and fft_done in COMPUTE: fft_done wins and the press is discarded.

Optional Feature:
FSM_WATCHDOG_EN
- Defined:
  - Cycle counter clears on entry to COMPUTE.
  - After TIMEOUT_CYCLES cycles in COMPUTE without fft_done: go to IDLE and set err_flag=1.
  - err_flag clears on the next press taken from IDLE.
  - fft_done arriving on the timeout cycle wins, giving OUT1 with no error.
- Not defined: COMPUTE waits indefinitely; err_flag tied 0; no counter logic.

Test Plan:
- Reset then idle -> fsm_state_out=0, all strobes 0. 1-cycle and 3-cycle btn glitches (DEBOUNCE_CYCLES=4) -> state stays 0, no press.
- Four clean presses from IDLE -> codes 1,2,3,4 in order. Presses 2..4 give load_en pulses with load_idx=0,1,2. Fifth press -> code 5, load_en with load_idx=3, fft_start=1 for one cycle.
- In COMPUTE, press held 20 cycles -> code stays 5. Then fft_done pulse -> code 6 next edge, out_en=1, out_idx=0.
- Three presses in OUT -> codes 7,8,9 with out_idx 1,2,3. Next press -> code 1, out_en=0.
- rst_n low while at code 3 with load_en high -> all outputs 0 asynchronously. Release -> IDLE; next press -> code 1.
- FSM_WATCHDOG_EN defined, TIMEOUT_CYCLES=64, no fft_done -> code 0 and err_flag=1 after 64 COMPUTE cycles; next press -> code 1, err_flag=0. Repeat with fft_done on cycle 64 -> code 6, err_flag=0.
